// File: rtl/button_event_ctrl.sv
// Button front end: two-flop synchronisers, per-button debounce and long-press
// detection, one pending slot per button, round-robin arbiter and a FWFT event FIFO.
module button_event_ctrl #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CLKS   = 625000,
    parameter int LONG_PRESS_CLKS = 25000000,
    parameter int FIFO_DEPTH      = 4,
    localparam int BTN_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_BUTTONS-1:0] i_buttons,
    output logic [NUM_BUTTONS-1:0] o_state,
    output logic                   o_evt_valid,
    input  logic                   i_evt_ready,
    output logic [BTN_W-1:0]       o_evt_btn,
    output logic [1:0]             o_evt_type,
    output logic                   o_overflow,
    input  logic                   i_clear_overflow
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CLKS) + 1;
    localparam int HOLD_W  = $clog2(LONG_PRESS_CLKS) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = BTN_W + 2;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_LONG    = 2'b11
    } evt_type_e;

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] state_q, state_d;
    logic [CNT_W-1:0]       cnt_q  [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_d  [NUM_BUTTONS];
    logic [HOLD_W-1:0]      hold_q [NUM_BUTTONS];
    logic [HOLD_W-1:0]      hold_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] fired_q, fired_d;
    logic [NUM_BUTTONS-1:0] slot_valid_q, slot_valid_d;
    evt_type_e              slot_type_q [NUM_BUTTONS];
    evt_type_e              slot_type_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] evt_new;
    evt_type_e              evt_new_type [NUM_BUTTONS];
    logic [BTN_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   grant_valid;
    logic [BTN_W-1:0]       grant_idx;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   push, pop;

    function automatic logic [BTN_W-1:0] rr_cand(input logic [BTN_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_BUTTONS) sum -= NUM_BUTTONS;
        return BTN_W'(sum);
    endfunction

    // Scan from the farthest offset down so the slot nearest rr_ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (slot_valid_q[rr_cand(rr_ptr_q, i)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_cand(rr_ptr_q, i);
            end
        end
        if (count_q == (PTR_W+1)'(FIFO_DEPTH)) grant_valid = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        fired_d      = fired_q;
        slot_valid_d = slot_valid_q;
        overflow_d   = i_clear_overflow ? 1'b0 : overflow_q;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            cnt_d[k]        = cnt_q[k];
            hold_d[k]       = hold_q[k];
            slot_type_d[k]  = slot_type_q[k];
            evt_new[k]      = 1'b0;
            evt_new_type[k] = EVT_NONE;

            if (sync2_q[k] == state_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_W'(DEBOUNCE_CLKS - 1)) begin
                state_d[k]      = sync2_q[k];
                cnt_d[k]        = '0;
                evt_new[k]      = 1'b1;
                evt_new_type[k] = sync2_q[k] ? EVT_PRESS : EVT_RELEASE;
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end

            // A release landing on the long-press edge takes the slot; the press is over anyway.
            if (!state_q[k]) begin
                hold_d[k]  = '0;
                fired_d[k] = 1'b0;
            end else if (!fired_q[k]) begin
                hold_d[k] = hold_q[k] + 1'b1;
                if (hold_q[k] == HOLD_W'(LONG_PRESS_CLKS - 1)) begin
                    fired_d[k] = 1'b1;
                    if (!evt_new[k]) begin
                        evt_new[k]      = 1'b1;
                        evt_new_type[k] = EVT_LONG;
                    end
                end
            end

            if (grant_valid && grant_idx == BTN_W'(k)) slot_valid_d[k] = 1'b0;
            if (evt_new[k]) begin
                if (slot_valid_q[k] && !(grant_valid && grant_idx == BTN_W'(k))) overflow_d = 1'b1;
                slot_valid_d[k] = 1'b1;
                slot_type_d[k]  = evt_new_type[k];
            end
        end
    end

    assign push     = grant_valid;
    assign pop      = (count_q != '0) && i_evt_ready;
    assign rr_ptr_d = grant_valid ? rr_cand(grant_idx, 1) : rr_ptr_q;
    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= '0;
            fired_q      <= '0;
            slot_valid_q <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                cnt_q[k]       <= '0;
                hold_q[k]      <= '0;
                slot_type_q[k] <= EVT_NONE;
            end
        end else begin
            sync1_q      <= i_buttons;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            fired_q      <= fired_d;
            slot_valid_q <= slot_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                cnt_q[k]       <= cnt_d[k];
                hold_q[k]      <= hold_d[k];
                slot_type_q[k] <= slot_type_d[k];
            end
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so stale entries are never observed.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) mem_q[wr_ptr_q] <= {grant_idx, slot_type_q[grant_idx]};
    end

    assign o_state     = state_q;
    assign o_evt_valid = (count_q != '0);
    assign o_evt_btn   = mem_q[rd_ptr_q][ENTRY_W-1:2];
    assign o_evt_type  = mem_q[rd_ptr_q][1:0];
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with short debounce/long-press timing;
// popped events are logged at the falling edge and compared against hand-derived lists.
module tb_button_event_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_buttons = 4'b0000;
    logic       i_evt_ready = 1'b1;
    logic       i_clear_overflow = 1'b0;
    logic [3:0] o_state;
    logic       o_evt_valid;
    logic [1:0] o_evt_btn;
    logic [1:0] o_evt_type;
    logic       o_overflow;

    int errors = 0;
    int checks = 0;
    logic [3:0] evq [$];
    logic [3:0] exp_q [$];

    button_event_ctrl #(
        .NUM_BUTTONS(4), .DEBOUNCE_CLKS(4), .LONG_PRESS_CLKS(20), .FIFO_DEPTH(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_buttons(i_buttons), .o_state(o_state),
        .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready), .o_evt_btn(o_evt_btn),
        .o_evt_type(o_evt_type), .o_overflow(o_overflow), .i_clear_overflow(i_clear_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Inputs only change 1 time unit after a rising edge, so this sees what the next edge pops.
    always @(negedge i_clk) begin
        if (!i_rst && o_evt_valid && i_evt_ready) evq.push_back({o_evt_btn, o_evt_type});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_buttons = 4'b0000;
        i_evt_ready = 1'b1;
        i_clear_overflow = 1'b0;
        i_rst = 1'b1;
        step(3);
        i_rst = 1'b0;
        step(1);
        evq.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_buttons = 4'b1111;
        step(10);
        checks++;
        if (o_state !== 4'b0000) begin errors++; $display("FAIL reset_state: got %b want 0000", o_state); end
        checks++;
        if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_evt_valid); end
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
        do_reset();
    endtask

    task automatic test_single_press();
        do_reset();
        i_buttons[2] = 1'b1;
        step(5);
        checks++;
        if (o_state !== 4'b0000) begin errors++; $display("FAIL press_state_early: got %b want 0000", o_state); end
        step(1);
        checks++;
        if (o_state !== 4'b0100) begin errors++; $display("FAIL press_state_edge: got %b want 0100", o_state); end
        checks++;
        if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL press_valid_early: got %b want 0", o_evt_valid); end
        step(1);
        checks++;
        if ({o_evt_valid, o_evt_btn, o_evt_type} !== 5'b1_10_01) begin
            errors++; $display("FAIL press_head: got %b want 11001", {o_evt_valid, o_evt_btn, o_evt_type});
        end
        step(1);
        checks++;
        if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL press_popped: got %b want 0", o_evt_valid); end
        step(4);
        exp_q = '{4'b1001};
        checks++;
        if (evq.size() != exp_q.size()) begin
            errors++; $display("FAIL press_count: got %0d events want %0d", evq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (evq[i] !== exp_q[i]) begin errors++; $display("FAIL press_evt%0d: got %b want %b", i, evq[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_buttons[1] = ~i[0];
            step(2);
        end
        checks++;
        if (o_state !== 4'b0000) begin errors++; $display("FAIL bounce_state_during: got %b want 0000", o_state); end
        i_buttons[1] = 1'b1;
        step(5);
        checks++;
        if (o_state !== 4'b0000) begin errors++; $display("FAIL bounce_state_early: got %b want 0000", o_state); end
        step(1);
        checks++;
        if (o_state !== 4'b0010) begin errors++; $display("FAIL bounce_state_edge: got %b want 0010", o_state); end
        step(4);
        exp_q = '{4'b0101};
        checks++;
        if (evq.size() != exp_q.size()) begin
            errors++; $display("FAIL bounce_count: got %0d events want %0d", evq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (evq[i] !== exp_q[i]) begin errors++; $display("FAIL bounce_evt%0d: got %b want %b", i, evq[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_long_press();
        do_reset();
        i_buttons[0] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step(1);
            if (n == 26) begin
                checks++;
                if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL long_early: got %b want 0", o_evt_valid); end
            end
            if (n == 27) begin
                checks++;
                if ({o_evt_valid, o_evt_btn, o_evt_type} !== 5'b1_00_11) begin
                    errors++; $display("FAIL long_head: got %b want 10011", {o_evt_valid, o_evt_btn, o_evt_type});
                end
            end
        end
        i_buttons[0] = 1'b0;
        step(10);
        exp_q = '{4'b0001, 4'b0011, 4'b0010};
        checks++;
        if (evq.size() != exp_q.size()) begin
            errors++; $display("FAIL long_count: got %0d events want %0d", evq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (evq[i] !== exp_q[i]) begin errors++; $display("FAIL long_evt%0d: got %b want %b", i, evq[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_buttons[0] = 1'b1;
        step(8);
        i_buttons[0] = 1'b0;
        step(12);
        checks++;
        if (evq.size() != 2) begin errors++; $display("FAIL rr_setup_count: got %0d events want 2", evq.size()); end
        evq.delete();
        i_buttons = 4'b1001;
        step(7);
        checks++;
        if ({o_evt_valid, o_evt_btn, o_evt_type} !== 5'b1_11_01) begin
            errors++; $display("FAIL rr_first: got %b want 11101", {o_evt_valid, o_evt_btn, o_evt_type});
        end
        step(1);
        checks++;
        if ({o_evt_valid, o_evt_btn, o_evt_type} !== 5'b1_00_01) begin
            errors++; $display("FAIL rr_second: got %b want 10001", {o_evt_valid, o_evt_btn, o_evt_type});
        end
        step(1);
        checks++;
        if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b want 0", o_evt_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        i_evt_ready = 1'b0;
        i_buttons[1] = 1'b1;
        step(8);
        i_buttons[1] = 1'b0;
        step(8);
        i_buttons[1] = 1'b1;
        step(8);
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pending_only: got %b want 0", o_overflow); end
        i_buttons[1] = 1'b0;
        step(8);
        checks++;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
        checks++;
        if ({o_evt_valid, o_evt_btn, o_evt_type} !== 5'b1_01_01) begin
            errors++; $display("FAIL ovf_head: got %b want 10101", {o_evt_valid, o_evt_btn, o_evt_type});
        end
        evq.delete();
        i_evt_ready = 1'b1;
        step(8);
        exp_q = '{4'b0101, 4'b0110, 4'b0110};
        checks++;
        if (evq.size() != exp_q.size()) begin
            errors++; $display("FAIL ovf_count: got %0d events want %0d", evq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (evq[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_evt%0d: got %b want %b", i, evq[i], exp_q[i]); end
            end
        end
        checks++;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
        i_clear_overflow = 1'b1;
        step(1);
        i_clear_overflow = 1'b0;
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", o_overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_buttons[2] = 1'b1;
        step(3);
        i_rst = 1'b1;
        step(1);
        checks++;
        if ({o_evt_valid, o_state} !== 5'b0_0000) begin
            errors++; $display("FAIL rst_debounce: got %b want 00000", {o_evt_valid, o_state});
        end
        step(1);
        i_rst = 1'b0;
        step(5);
        checks++;
        if ({o_evt_valid, o_state} !== 5'b0_0000) begin
            errors++; $display("FAIL rst_redebounce_early: got %b want 00000", {o_evt_valid, o_state});
        end
        step(1);
        checks++;
        if (o_state !== 4'b0100) begin errors++; $display("FAIL rst_redebounce_state: got %b want 0100", o_state); end
        step(1);
        checks++;
        if ({o_evt_valid, o_evt_btn, o_evt_type} !== 5'b1_10_01) begin
            errors++; $display("FAIL rst_redebounce_evt: got %b want 11001", {o_evt_valid, o_evt_btn, o_evt_type});
        end

        do_reset();
        i_evt_ready = 1'b0;
        i_buttons[3] = 1'b1;
        step(7);
        checks++;
        if (o_evt_valid !== 1'b1) begin errors++; $display("FAIL rst_fifo_setup: got %b want 1", o_evt_valid); end
        i_rst = 1'b1;
        i_buttons = 4'b0000;
        step(1);
        checks++;
        if ({o_evt_valid, o_state} !== 5'b0_0000) begin
            errors++; $display("FAIL rst_fifo: got %b want 00000", {o_evt_valid, o_state});
        end
        i_rst = 1'b0;
        i_evt_ready = 1'b1;
        evq.delete();
        step(10);
        checks++;
        if (evq.size() != 0 || o_evt_valid !== 1'b0) begin
            errors++; $display("FAIL rst_fifo_empty: got %0d events valid=%b want 0 events valid=0", evq.size(), o_evt_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_long_press();
        test_round_robin();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
